reg_bank: RTL and testbench

Parametrised register bank with an operation unit. It replaces the single 4-bit bus-loaded register in the processor datapath. It holds DEPTH registers of WIDTH bits and performs one register operation per clock (load from DBUS, increment, decrement, shift, rotate, clear) on the register selected by WAddr. Two asynchronous read ports drive the ALU and the LEDG/debug outputs, and a Carry flag records the bit lost by the last arithmetic or shift operation.

---
 rtl/reg_bank.sv | 108 ++++++++++
 tb/tb_reg_bank.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank.sv
// Register bank with a single-cycle operation unit (load/inc/dec/shift/rotate/clear)
// acting on one register per clock, two combinational read ports and a carry flag.
module reg_bank #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] DBUS,
  input  logic             Wn,
  input  logic [AW-1:0]    WAddr,
  input  logic [2:0]       Op,
  input  logic [AW-1:0]    RAddrA,
  input  logic [AW-1:0]    RAddrB,
  output logic [WIDTH-1:0] QA,
  output logic [WIDTH-1:0] QB,
  output logic             Carry,
  output logic             Zero
);

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_INC  = 3'b010;
  localparam logic [2:0] OP_DEC  = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_CLR  = 3'b110;
  localparam logic [2:0] OP_ROL  = 3'b111;

  logic [WIDTH-1:0] reg_val [DEPTH];
  logic [WIDTH-1:0] wr_cur;
  logic [WIDTH-1:0] wr_d;
  logic             carry_q;
  logic             carry_d;
  logic             waddr_ok;
  logic             exec;

  assign waddr_ok = (int'(WAddr) < DEPTH);
  assign exec     = ~Wn && waddr_ok;

  // Address decode by comparison, so out-of-range addresses read as 0 without aliasing.
  always_comb begin
    QA     = '0;
    QB     = '0;
    wr_cur = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (int'(RAddrA) == i) QA = reg_val[i];
      if (int'(RAddrB) == i) QB = reg_val[i];
      if (int'(WAddr) == i)  wr_cur = reg_val[i];
    end
  end

  always_comb begin
    wr_d    = wr_cur;
    carry_d = carry_q;
    case (Op)
      OP_HOLD: ;
      OP_LOAD: wr_d = DBUS;
      OP_INC:  {carry_d, wr_d} = {1'b0, wr_cur} + (WIDTH+1)'(1);
      // The top bit of the widened difference is the borrow.
      OP_DEC:  {carry_d, wr_d} = {1'b0, wr_cur} - (WIDTH+1)'(1);
      OP_SHL: begin
        carry_d = wr_cur[WIDTH-1];
        wr_d    = {wr_cur[WIDTH-2:0], 1'b0};
      end
      OP_SHR: begin
        carry_d = wr_cur[0];
        wr_d    = {1'b0, wr_cur[WIDTH-1:1]};
      end
      OP_CLR: begin
        carry_d = 1'b0;
        wr_d    = '0;
      end
      OP_ROL: begin
        carry_d = wr_cur[WIDTH-1];
        wr_d    = {wr_cur[WIDTH-2:0], wr_cur[WIDTH-1]};
      end
      default: ;
    endcase
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge Clock) begin
      if (Reset) begin
        r_q <= '0;
      end else if (exec && (int'(WAddr) == gi)) begin
        r_q <= wr_d;
      end
    end

    assign reg_val[gi] = r_q;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      carry_q <= 1'b0;
    end else if (exec) begin
      carry_q <= carry_d;
    end
  end

  assign Carry = carry_q;
  assign Zero  = waddr_ok && (wr_cur == '0);

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: a 4x4 bank, a 4-bit x 3-deep bank (out-of-range
// addresses) and an 8x8 bank (wide wrap-around), with expected results queued per operation.
module tb_reg_bank;

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_INC  = 3'b010;
  localparam logic [2:0] OP_DEC  = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_CLR  = 3'b110;
  localparam logic [2:0] OP_ROL  = 3'b111;

  typedef struct {
    int         d;
    logic [2:0] addr;
    logic [7:0] val;
    logic       c;
    string      name;
  } exp_t;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       wn    [3];
  logic [2:0] op    [3];
  logic [2:0] waddr [3];
  logic [2:0] ra    [3];
  logic [2:0] rb    [3];
  logic [7:0] dbus  [3];

  logic [3:0] qa0, qb0, qa1, qb1;
  logic [7:0] qa2, qb2;
  logic       c0, c1, c2, z0, z1, z2;

  logic [7:0] qa_s    [3];
  logic [7:0] qb_s    [3];
  logic       carry_s [3];
  logic       zero_s  [3];

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 Clock = ~Clock;

  reg_bank #(.WIDTH(4), .DEPTH(4)) u_dut0 (
    .Clock(Clock), .Reset(Reset), .DBUS(dbus[0][3:0]), .Wn(wn[0]),
    .WAddr(waddr[0][1:0]), .Op(op[0]), .RAddrA(ra[0][1:0]), .RAddrB(rb[0][1:0]),
    .QA(qa0), .QB(qb0), .Carry(c0), .Zero(z0)
  );

  reg_bank #(.WIDTH(4), .DEPTH(3)) u_dut1 (
    .Clock(Clock), .Reset(Reset), .DBUS(dbus[1][3:0]), .Wn(wn[1]),
    .WAddr(waddr[1][1:0]), .Op(op[1]), .RAddrA(ra[1][1:0]), .RAddrB(rb[1][1:0]),
    .QA(qa1), .QB(qb1), .Carry(c1), .Zero(z1)
  );

  reg_bank #(.WIDTH(8), .DEPTH(8)) u_dut2 (
    .Clock(Clock), .Reset(Reset), .DBUS(dbus[2]), .Wn(wn[2]),
    .WAddr(waddr[2]), .Op(op[2]), .RAddrA(ra[2]), .RAddrB(rb[2]),
    .QA(qa2), .QB(qb2), .Carry(c2), .Zero(z2)
  );

  assign qa_s[0] = {4'b0, qa0};
  assign qa_s[1] = {4'b0, qa1};
  assign qa_s[2] = qa2;
  assign qb_s[0] = {4'b0, qb0};
  assign qb_s[1] = {4'b0, qb1};
  assign qb_s[2] = qb2;
  assign carry_s[0] = c0;
  assign carry_s[1] = c1;
  assign carry_s[2] = c2;
  assign zero_s[0]  = z0;
  assign zero_s[1]  = z1;
  assign zero_s[2]  = z2;

  // One clocked operation on bank d; the expected post-edge value of register a and Carry
  // is queued at drive time and compared once the edge has produced it.
  task automatic step(input int d, input logic rst, input logic w, input logic [2:0] o,
                      input logic [2:0] a, input logic [7:0] db,
                      input logic [7:0] ev, input logic ec, input string nm);
    exp_t e;
    Reset    = rst;
    wn[d]    = w;
    op[d]    = o;
    waddr[d] = a;
    dbus[d]  = db;
    e.d = d; e.addr = a; e.val = ev; e.c = ec; e.name = nm;
    sb.push_back(e);
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    wn[d] = 1'b1;
    e = sb.pop_front();
    ra[e.d] = e.addr;
    #1;
    n_total++;
    if (qa_s[e.d] !== e.val)
      $display("FAIL %s value: got %h expected %h", e.name, qa_s[e.d], e.val);
    else n_pass++;
    n_total++;
    if (carry_s[e.d] !== e.c)
      $display("FAIL %s carry: got %b expected %b", e.name, carry_s[e.d], e.c);
    else n_pass++;
  endtask

  task automatic test_reset();
    for (int a = 0; a < 4; a++) begin
      ra[0] = 3'(a);
      rb[0] = 3'(a);
      #1;
      n_total++;
      if (qa_s[0] !== 8'h00) $display("FAIL reset_qa[%0d]: got %h expected 00", a, qa_s[0]);
      else n_pass++;
      n_total++;
      if (qb_s[0] !== 8'h00) $display("FAIL reset_qb[%0d]: got %h expected 00", a, qb_s[0]);
      else n_pass++;
    end
    n_total++;
    if (carry_s[0] !== 1'b0) $display("FAIL reset_carry: got %b expected 0", carry_s[0]);
    else n_pass++;
    n_total++;
    if (zero_s[0] !== 1'b1) $display("FAIL reset_zero: got %b expected 1", zero_s[0]);
    else n_pass++;
    n_total++;
    if (zero_s[1] !== 1'b0) $display("FAIL reset_zero_oob: got %b expected 0", zero_s[1]);
    else n_pass++;
  endtask

  task automatic test_load();
    step(0, 1'b0, 1'b0, OP_LOAD, 3'd2, 8'h0A, 8'h0A, 1'b0, "load_r2");
    for (int a = 0; a < 4; a++) begin
      if (a != 2) begin
        rb[0] = 3'(a);
        #1;
        n_total++;
        if (qb_s[0] !== 8'h00) $display("FAIL load_other[%0d]: got %h expected 00", a, qb_s[0]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_inc_dec();
    step(0, 1'b0, 1'b0, OP_LOAD, 3'd1, 8'h0F, 8'h0F, 1'b0, "load_r1");
    step(0, 1'b0, 1'b0, OP_INC,  3'd1, 8'h00, 8'h00, 1'b1, "inc_wrap");
    n_total++;
    if (zero_s[0] !== 1'b1) $display("FAIL inc_zero: got %b expected 1", zero_s[0]);
    else n_pass++;
    step(0, 1'b0, 1'b0, OP_DEC,  3'd1, 8'h00, 8'h0F, 1'b1, "dec_borrow");
    n_total++;
    if (zero_s[0] !== 1'b0) $display("FAIL dec_zero: got %b expected 0", zero_s[0]);
    else n_pass++;
    step(0, 1'b0, 1'b0, OP_DEC,  3'd1, 8'h00, 8'h0E, 1'b0, "dec_plain");
  endtask

  task automatic test_shift();
    step(0, 1'b0, 1'b0, OP_LOAD, 3'd0, 8'h09, 8'h09, 1'b0, "load_r0");
    step(0, 1'b0, 1'b0, OP_SHL,  3'd0, 8'h00, 8'h02, 1'b1, "shl");
    step(0, 1'b0, 1'b0, OP_SHR,  3'd0, 8'h00, 8'h01, 1'b0, "shr");
    step(0, 1'b0, 1'b0, OP_LOAD, 3'd0, 8'h09, 8'h09, 1'b0, "reload_r0");
    step(0, 1'b0, 1'b0, OP_ROL,  3'd0, 8'h00, 8'h03, 1'b1, "rol");
    step(0, 1'b0, 1'b0, OP_CLR,  3'd0, 8'h00, 8'h00, 1'b0, "clr");
  endtask

  task automatic test_hold();
    step(0, 1'b0, 1'b0, OP_LOAD, 3'd0, 8'h08, 8'h08, 1'b0, "load_r0_8");
    step(0, 1'b0, 1'b0, OP_SHL,  3'd0, 8'h00, 8'h00, 1'b1, "shl_out");
    for (int i = 0; i < 3; i++)
      step(0, 1'b0, 1'b1, OP_LOAD, 3'd0, 8'h05, 8'h00, 1'b1, "hold_wn1");
  endtask

  task automatic test_back_to_back();
    // Read-during-write: QA shows the pre-edge value before the edge.
    ra[0]    = 3'd3;
    waddr[0] = 3'd3;
    op[0]    = OP_LOAD;
    dbus[0]  = 8'h07;
    wn[0]    = 1'b0;
    #1;
    n_total++;
    if (qa_s[0] !== 8'h00) $display("FAIL rdw_old: got %h expected 00", qa_s[0]);
    else n_pass++;
    step(0, 1'b0, 1'b0, OP_LOAD, 3'd3, 8'h07, 8'h07, 1'b1, "rdw_new");
    step(0, 1'b0, 1'b0, OP_INC,  3'd3, 8'h00, 8'h08, 1'b0, "b2b_inc1");
    step(0, 1'b0, 1'b0, OP_INC,  3'd3, 8'h00, 8'h09, 1'b0, "b2b_inc2");
  endtask

  task automatic test_depth3();
    step(1, 1'b0, 1'b0, OP_LOAD, 3'd0, 8'h09, 8'h09, 1'b0, "d3_load_r0");
    step(1, 1'b0, 1'b0, OP_SHL,  3'd0, 8'h00, 8'h02, 1'b1, "d3_shl");
    step(1, 1'b0, 1'b0, OP_LOAD, 3'd3, 8'h06, 8'h00, 1'b1, "d3_oob_load");
    step(1, 1'b0, 1'b0, OP_CLR,  3'd3, 8'h00, 8'h00, 1'b1, "d3_oob_clr");
    for (int a = 0; a < 3; a++) begin
      ra[1] = 3'(a);
      #1;
      n_total++;
      if (qa_s[1] !== ((a == 0) ? 8'h02 : 8'h00))
        $display("FAIL d3_reg[%0d]: got %h expected %h", a, qa_s[1], (a == 0) ? 8'h02 : 8'h00);
      else n_pass++;
    end
    rb[1] = 3'd3;
    #1;
    n_total++;
    if (qb_s[1] !== 8'h00) $display("FAIL d3_qb_oob: got %h expected 00", qb_s[1]);
    else n_pass++;
    n_total++;
    if (zero_s[1] !== 1'b0) $display("FAIL d3_zero_oob: got %b expected 0", zero_s[1]);
    else n_pass++;
  endtask

  task automatic test_wide();
    step(2, 1'b0, 1'b0, OP_LOAD, 3'd5, 8'hFF, 8'hFF, 1'b0, "w8_load");
    step(2, 1'b0, 1'b0, OP_INC,  3'd5, 8'h00, 8'h00, 1'b1, "w8_inc_wrap");
    n_total++;
    if (zero_s[2] !== 1'b1) $display("FAIL w8_zero: got %b expected 1", zero_s[2]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    step(0, 1'b0, 1'b0, OP_LOAD, 3'd1, 8'h05, 8'h05, 1'b0, "rm_load_r1");
    step(0, 1'b0, 1'b0, OP_LOAD, 3'd2, 8'h08, 8'h08, 1'b0, "rm_load_r2");
    step(0, 1'b0, 1'b0, OP_SHL,  3'd2, 8'h00, 8'h00, 1'b1, "rm_set_carry");
    step(0, 1'b1, 1'b0, OP_LOAD, 3'd1, 8'h0C, 8'h00, 1'b0, "rm_reset_wins");
  endtask

  initial begin
    Reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      wn[d]    = 1'b1;
      op[d]    = OP_HOLD;
      waddr[d] = (d == 1) ? 3'd3 : 3'd0;
      ra[d]    = 3'd0;
      rb[d]    = 3'd0;
      dbus[d]  = 8'h00;
    end
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b0;
    #1;
    test_reset();
    test_load();
    test_inc_dec();
    test_shift();
    test_hold();
    test_back_to_back();
    test_depth3();
    test_wide();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
